// File: rtl/jtshouse_scr_rom_pkg.sv
// Shared types and widths for the C123 tilemap ROM responder.
package jtshouse_scr_pkg;
  typedef enum logic {CL_MASK = 1'b0, CL_SCR = 1'b1} client_t;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RETRY = 2'd2} state_t;
  localparam int MASK_AW = 17;
  localparam int SCR_AW  = 20;
endpackage

// File: rtl/jtshouse_scr_rom_line.sv
// One-word cache for a single ROM client: tag/word/valid plus combinational ok and byte select.
module jtshouse_scr_rom_line #(
  parameter int AW = 17
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  input  logic          fill,
  input  logic [AW-2:0] fill_tag,
  input  logic [15:0]   fill_data,
  output logic          ok,
  output logic [7:0]    data
);
  logic          valid;
  logic [AW-2:0] tag;
  logic [15:0]   word;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      tag   <= '0;
      word  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (fill) begin
      valid <= 1'b1;
      tag   <= fill_tag;
      word  <= fill_data;
    end
  end

  // ok must track the live address: a different word drops it in the same cycle
  assign ok   = cs & valid & ~flush & (tag == addr[AW-1:1]);
  assign data = addr[0] ? word[15:8] : word[7:0];
endmodule

// File: rtl/jtshouse_scr_rom.sv
// Mask/tile ROM responder: two 1-word caches sharing one SDRAM slot with alternating arbitration and timeout retry.
module jtshouse_scr_rom
  import jtshouse_scr_pkg::*;
#(
  parameter int            AW          = 22,
  parameter logic [AW-1:0] MASK_OFFSET = AW'(22'h00_0000),
  parameter logic [AW-1:0] SCR_OFFSET  = AW'(22'h01_0000),
  parameter int            TOUT        = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                mask_cs,
  input  logic [MASK_AW-1:0]  mask_addr,
  output logic                mask_ok,
  output logic [7:0]          mask_data,
  input  logic                scr_cs,
  input  logic [SCR_AW-1:0]   scr_addr,
  output logic                scr_ok,
  output logic [7:0]          scr_data,
  output logic                rom_cs,
  output logic [AW-1:0]       rom_addr,
  input  logic                rom_ok,
  input  logic [15:0]         rom_data,
  output logic [7:0]          st_dout
);
  state_t            state;
  client_t           gnt, last_grant, pick;
  logic [SCR_AW-2:0] req_tag, next_tag;
  logic [AW-1:0]     next_addr;
  logic [7:0]        tcnt;
  logic [3:0]        retry_cnt;
  logic              mask_miss, scr_miss, fill_ok;

  assign mask_miss = mask_cs & ~mask_ok;
  assign scr_miss  = scr_cs & ~scr_ok;
  assign fill_ok   = (state == WAIT) & rom_ok & ~flush;

  always_comb begin
    pick = CL_MASK;
    if (mask_miss && scr_miss) pick = client_t'(~last_grant);
    else if (scr_miss)         pick = CL_SCR;
    if (pick == CL_SCR) begin
      next_tag  = scr_addr[SCR_AW-1:1];
      next_addr = SCR_OFFSET + AW'(scr_addr[SCR_AW-1:1]);
    end else begin
      next_tag  = (SCR_AW-1)'(mask_addr[MASK_AW-1:1]);
      next_addr = MASK_OFFSET + AW'(mask_addr[MASK_AW-1:1]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      gnt        <= CL_MASK;
      last_grant <= CL_SCR;
      req_tag    <= '0;
      rom_cs     <= 1'b0;
      rom_addr   <= '0;
      tcnt       <= '0;
      retry_cnt  <= '0;
      st_dout    <= '0;
    end else begin
      st_dout <= {retry_cnt, state, last_grant, state != IDLE};
      if (flush) begin
        state  <= IDLE;
        rom_cs <= 1'b0;
      end else begin
        case (state)
          IDLE: if (mask_miss || scr_miss) begin
            gnt      <= pick;
            req_tag  <= next_tag;
            rom_addr <= next_addr;
            rom_cs   <= 1'b1;
            tcnt     <= '0;
            state    <= WAIT;
          end
          WAIT: if (rom_ok) begin
            rom_cs     <= 1'b0;
            last_grant <= gnt;
            state      <= IDLE;
          end else if (tcnt == 8'(TOUT - 1)) begin
            rom_cs <= 1'b0;
            if (retry_cnt != 4'hf) retry_cnt <= retry_cnt + 4'd1;
            state  <= RETRY;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
          RETRY: begin
            rom_cs <= 1'b1;
            tcnt   <= '0;
            state  <= WAIT;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  jtshouse_scr_rom_line #(.AW(MASK_AW)) u_mask (
    .clk(clk), .rst_n(rst_n), .flush(flush), .cs(mask_cs), .addr(mask_addr),
    .fill(fill_ok && gnt == CL_MASK), .fill_tag(req_tag[MASK_AW-2:0]), .fill_data(rom_data),
    .ok(mask_ok), .data(mask_data)
  );

  jtshouse_scr_rom_line #(.AW(SCR_AW)) u_scr (
    .clk(clk), .rst_n(rst_n), .flush(flush), .cs(scr_cs), .addr(scr_addr),
    .fill(fill_ok && gnt == CL_SCR), .fill_tag(req_tag), .fill_data(rom_data),
    .ok(scr_ok), .data(scr_data)
  );
endmodule
